// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - raster timing and four-pattern test image generator
module vga_pattern_gen #(
  parameter int   H_TOTAL   = 2200-1,
  parameter int   H_SYNC    = 44-1,
  parameter int   H_START   = 190-1,
  parameter int   H_END     = 2110-1,
  parameter int   V_TOTAL   = 1125-1,
  parameter int   V_SYNC    = 5-1,
  parameter int   V_START   = 41-1,
  parameter int   V_END     = 1121-1,
  parameter int   SCREEN_X  = 1920,
  parameter int   SCREEN_Y  = 1080,
  parameter int   SQUARE_X  = 500,
  parameter int   SQUARE_Y  = 500,
  parameter int   STEP      = 4,
  parameter int   COLOR_W   = 8,
  parameter int   CELL_LOG2 = 5,
  parameter logic SYNC_POL  = 1'b1
) (
  input  logic                 vpg_pclk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] fg_color,
  output logic                 vpg_de,
  output logic                 vpg_hs,
  output logic                 vpg_vs,
  output logic [COLOR_W-1:0]   rgb_r,
  output logic [COLOR_W-1:0]   rgb_g,
  output logic [COLOR_W-1:0]   rgb_b,
  output logic                 frame_start
);

  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int PW = 3 * COLOR_W;

  localparam logic [HW-1:0] H_TOTAL_C = HW'(H_TOTAL);
  localparam logic [HW-1:0] H_SYNC_C  = HW'(H_SYNC);
  localparam logic [HW-1:0] H_START_C = HW'(H_START);
  localparam logic [HW-1:0] H_END_C   = HW'(H_END);
  localparam logic [HW-1:0] H_ONE     = HW'(1);
  localparam logic [HW-1:0] X_OFF     = HW'(H_START + 1);
  localparam logic [HW-1:0] SQ_W_X    = HW'(SQUARE_X);
  localparam logic [HW-1:0] SQ_MAX_X  = HW'(SCREEN_X - SQUARE_X);
  localparam logic [HW-1:0] STEP_X    = HW'(STEP);
  localparam logic [HW-1:0] BAR_LAST  = HW'(SCREEN_X / 8 - 1);

  localparam logic [VW-1:0] V_TOTAL_C = VW'(V_TOTAL);
  localparam logic [VW-1:0] V_SYNC_C  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_START_C = VW'(V_START);
  localparam logic [VW-1:0] V_END_C   = VW'(V_END);
  localparam logic [VW-1:0] V_ONE     = VW'(1);
  localparam logic [VW-1:0] Y_OFF     = VW'(V_START + 1);
  localparam logic [VW-1:0] SQ_W_Y    = VW'(SQUARE_Y);
  localparam logic [VW-1:0] SQ_MAX_Y  = VW'(SCREEN_Y - SQUARE_Y);
  localparam logic [VW-1:0] STEP_Y    = VW'(STEP);

  logic [HW-1:0] hcnt, x, sq_x, bar_cnt;
  logic [VW-1:0] vcnt, y, sq_y;
  logic          dir_x, dir_y;
  logic [2:0]    bar_k, bar_rgb;
  logic [1:0]    mode_s;
  logic [PW-1:0] fg_s, pix;
  logic          active, frame_end, in_sq;

  assign frame_end = (hcnt == H_TOTAL_C) && (vcnt == V_TOTAL_C);
  assign active    = (hcnt > H_START_C) && (hcnt <= H_END_C) &&
                     (vcnt > V_START_C) && (vcnt <= V_END_C);
  assign x         = hcnt - X_OFF;
  assign y         = vcnt - Y_OFF;
  assign in_sq     = (x >= sq_x) && (x < sq_x + SQ_W_X) &&
                     (y >= sq_y) && (y < sq_y + SQ_W_Y);

  // Raster counters: hcnt wraps every line, vcnt advances at line end
  always_ff @(posedge vpg_pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_TOTAL_C) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_TOTAL_C) ? '0 : vcnt + V_ONE;
    end else begin
      hcnt <= hcnt + H_ONE;
    end
  end

  // Square bounces at frame end, clamped to the screen; runs in every mode
  always_ff @(posedge vpg_pclk or negedge rst_n) begin
    if (!rst_n) begin
      sq_x  <= '0;
      sq_y  <= '0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
    end else if (frame_end) begin
      if (dir_x) begin
        if (sq_x + STEP_X >= SQ_MAX_X) begin
          sq_x  <= SQ_MAX_X;
          dir_x <= 1'b0;
        end else begin
          sq_x <= sq_x + STEP_X;
        end
      end else if (sq_x <= STEP_X) begin
        sq_x  <= '0;
        dir_x <= 1'b1;
      end else begin
        sq_x <= sq_x - STEP_X;
      end
      if (dir_y) begin
        if (sq_y + STEP_Y >= SQ_MAX_Y) begin
          sq_y  <= SQ_MAX_Y;
          dir_y <= 1'b0;
        end else begin
          sq_y <= sq_y + STEP_Y;
        end
      end else if (sq_y <= STEP_Y) begin
        sq_y  <= '0;
        dir_y <= 1'b1;
      end else begin
        sq_y <= sq_y - STEP_Y;
      end
    end
  end

  // Mode and colour are only taken at frame end so a frame is never torn
  always_ff @(posedge vpg_pclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_s <= '0;
      fg_s   <= '0;
    end else if (frame_end) begin
      mode_s <= mode;
      fg_s   <= fg_color;
    end
  end

  // Bar index from a running pixel counter; bar 7 holds to absorb the remainder
  always_ff @(posedge vpg_pclk or negedge rst_n) begin
    if (!rst_n) begin
      bar_cnt <= '0;
      bar_k   <= '0;
    end else if (!active) begin
      bar_cnt <= '0;
      bar_k   <= '0;
    end else if (bar_k != 3'd7) begin
      if (bar_cnt == BAR_LAST) begin
        bar_cnt <= '0;
        bar_k   <= bar_k + 3'd1;
      end else begin
        bar_cnt <= bar_cnt + H_ONE;
      end
    end
  end

  // Bar palette as one bit per channel: white, yellow, cyan, green, magenta, red, blue, black
  always_comb begin
    bar_rgb = 3'b000;
    case (bar_k)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  end

  // Pattern select for the current raster position; black outside active video
  always_comb begin
    pix = '0;
    if (active) begin
      case (mode_s)
        2'd0:    pix = fg_s;
        2'd1:    pix = {{COLOR_W{bar_rgb[2]}}, {COLOR_W{bar_rgb[1]}}, {COLOR_W{bar_rgb[0]}}};
        2'd2:    pix = (x[CELL_LOG2] ^ y[CELL_LOG2]) ? '1 : '0;
        default: pix = in_sq ? fg_s : '0;
      endcase
    end
  end

  // Output register: everything leaves one clock after its raster position
  always_ff @(posedge vpg_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vpg_de      <= 1'b0;
      vpg_hs      <= ~SYNC_POL;
      vpg_vs      <= ~SYNC_POL;
      rgb_r       <= '0;
      rgb_g       <= '0;
      rgb_b       <= '0;
      frame_start <= 1'b0;
    end else begin
      vpg_de      <= active;
      vpg_hs      <= (hcnt <= H_SYNC_C) ? SYNC_POL : ~SYNC_POL;
      vpg_vs      <= (vcnt <= V_SYNC_C) ? SYNC_POL : ~SYNC_POL;
      rgb_r       <= pix[PW-1 -: COLOR_W];
      rgb_g       <= pix[2*COLOR_W-1 -: COLOR_W];
      rgb_b       <= pix[COLOR_W-1:0];
      frame_start <= (hcnt == '0) && (vcnt == '0);
    end
  end

endmodule
